// File: rtl/shift_latch.sv
`default_nettype none
// ============================================================================
// Module   : shift_latch
// Purpose  : 74HC595 8-bit serial-in/parallel-out shift register with
//            storage latch; SRCLK/RCLK edge-detected on the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module shift_latch (
    input  logic clk,
    input  logic rst,
    output logic pin1,
    output logic pin2,
    output logic pin3,
    output logic pin4,
    output logic pin5,
    output logic pin6,
    output logic pin7,
    input  logic pin8,
    output logic pin9,
    input  logic pin10,
    input  logic pin11,
    input  logic pin12,
    input  logic pin13,
    input  logic pin14,
    output logic pin15,
    input  logic pin16
);

    logic [7:0] r_sr;
    logic [7:0] r_st;
    logic       r_sck_q;
    logic       r_rck_q;
    logic       w_shift;
    logic       w_store;
    logic       w_unused;

    // Power pins carry no logic
    assign w_unused = pin8 ^ pin16;

    assign w_shift = pin11 & ~r_sck_q;
    assign w_store = pin12 & ~r_rck_q;

    // Edge flops reset high so a pin already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= 8'h00;
            r_st    <= 8'h00;
            r_sck_q <= 1'b1;
            r_rck_q <= 1'b1;
        end else begin
            r_sck_q <= pin11;
            r_rck_q <= pin12;
            if (!pin10)
                r_sr <= 8'h00;
            else if (w_shift)
                r_sr <= {r_sr[6:0], pin14};
            if (w_store)
                r_st <= r_sr;
        end
    end

    assign pin15 = pin13 ? 1'bz : r_st[0];
    assign pin1  = pin13 ? 1'bz : r_st[1];
    assign pin2  = pin13 ? 1'bz : r_st[2];
    assign pin3  = pin13 ? 1'bz : r_st[3];
    assign pin4  = pin13 ? 1'bz : r_st[4];
    assign pin5  = pin13 ? 1'bz : r_st[5];
    assign pin6  = pin13 ? 1'bz : r_st[6];
    assign pin7  = pin13 ? 1'bz : r_st[7];
    assign pin9  = r_sr[7];

endmodule
`default_nettype wire

// File: tb/tb_shift_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_latch
// Purpose  : Directed self-checking bench for shift_latch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_latch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srclr_n = 1'b1;
    logic srclk = 1'b1;
    logic rclk = 1'b1;
    logic oe_n = 1'b0;
    logic ser = 1'b0;
    wire  qa, qb, qc, qd, qe, qf, qg, qh, qh_s;
    wire  [7:0] w_q;

    int errors = 0;
    int checks = 0;

    // Weak pull-ups make a released (high-impedance) output read as 1
    pullup pu_a (qa);
    pullup pu_b (qb);
    pullup pu_c (qc);
    pullup pu_d (qd);
    pullup pu_e (qe);
    pullup pu_f (qf);
    pullup pu_g (qg);
    pullup pu_h (qh);

    assign w_q = {qh, qg, qf, qe, qd, qc, qb, qa};

    always #5 clk = ~clk;

    shift_latch dut (
        .clk   (clk),
        .rst   (rst),
        .pin1  (qb),
        .pin2  (qc),
        .pin3  (qd),
        .pin4  (qe),
        .pin5  (qf),
        .pin6  (qg),
        .pin7  (qh),
        .pin8  (1'b0),
        .pin9  (qh_s),
        .pin10 (srclr_n),
        .pin11 (srclk),
        .pin12 (rclk),
        .pin13 (oe_n),
        .pin14 (ser),
        .pin15 (qa),
        .pin16 (1'b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        ser   = b;
        srclk = 1'b1;
        tick();
        srclk = 1'b0;
        tick();
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic latch();
        rclk = 1'b1;
        tick();
        rclk = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with both clocks high and outputs enabled
        ser = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_qh_serial", {7'b0, qh_s}, 8'h00);
        check("reset_q", w_q, 8'h00);

        // Held-high clocks at release must not produce a shift
        srclk = 1'b0;
        rclk  = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        check("no_edge_at_release", {7'b0, qh_s}, 8'h00);

        // Byte shift A5 then latch
        shift_byte(8'hA5);
        check("shift8_qh_serial", {7'b0, qh_s}, 8'h01);
        check("q_before_latch", w_q, 8'h00);
        rclk = 1'b1;
        tick();
        check("latch_latency", w_q, 8'hA5);
        rclk = 1'b0;
        tick();
        check("latch_a5", w_q, 8'hA5);

        // Output enable is combinational
        oe_n = 1'b1;
        #1;
        check("oe_off_q", w_q, 8'hFF);
        check("oe_off_serial", {7'b0, qh_s}, 8'h01);
        oe_n = 1'b0;
        #1;
        check("oe_on_q", w_q, 8'hA5);

        // Clear overrides a shift edge; storage untouched
        shift_byte(8'hFF);
        check("load_ff_serial", {7'b0, qh_s}, 8'h01);
        srclr_n = 1'b0;
        shift_bit(1'b1);
        check("clear_serial", {7'b0, qh_s}, 8'h00);
        check("clear_keeps_st", w_q, 8'hA5);
        srclr_n = 1'b1;
        tick();
        latch();
        check("clear_sr_zero", w_q, 8'h00);

        // Simultaneous shift and storage edges
        shift_byte(8'h0F);
        ser   = 1'b1;
        srclk = 1'b1;
        rclk  = 1'b1;
        tick();
        check("simul_st_pre_shift", w_q, 8'h0F);
        srclk = 1'b0;
        rclk  = 1'b0;
        tick();
        latch();
        check("simul_sr_post_shift", w_q, 8'h1F);

        // Reset mid-stream discards partial shift
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_serial", {7'b0, qh_s}, 8'h00);
        check("midrst_q", w_q, 8'h00);
        tick();
        shift_byte(8'h3C);
        latch();
        check("fresh_3c", w_q, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
